// File: rtl/instruction_fetch.sv
// Single-outstanding instruction fetch stage: REQ -> WAIT -> HOLD, with redirect
// handling that squashes in-flight responses and flushes the held instruction.
module instruction_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_inst,
  output logic [31:0] if_pc,
  output logic        misalign_pulse
);

  typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD} state_t;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
  } fetch_pkt_t;

  localparam logic [31:0] RESET_PC_A = {RESET_PC[31:2], 2'b00};

  state_t     r_state, w_state_nxt;
  logic [31:0] r_pc, w_pc_nxt;
  logic        r_kill, w_kill_nxt;
  logic        r_vld, w_vld_nxt;
  fetch_pkt_t  r_pkt, w_pkt_nxt;
  logic        r_misalign;
  logic [31:0] w_redir_pc;

  assign w_redir_pc = {redirect_pc[31:2], 2'b00};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= S_REQ;
      r_pc       <= RESET_PC_A;
      r_kill     <= 1'b0;
      r_vld      <= 1'b0;
      r_pkt      <= '{inst: NOP_INST, pc: 32'h0};
      r_misalign <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_pc       <= w_pc_nxt;
      r_kill     <= w_kill_nxt;
      r_vld      <= w_vld_nxt;
      r_pkt      <= w_pkt_nxt;
      r_misalign <= redirect_valid & (|redirect_pc[1:0]);
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_kill_nxt  = r_kill;
    w_vld_nxt   = r_vld;
    w_pkt_nxt   = r_pkt;
    if (redirect_valid) w_pc_nxt = w_redir_pc;
    case (r_state)
      S_REQ: begin
        // A redirect racing the accept still lets the old request go; its data is squashed.
        if (imem_req_ready) begin
          w_state_nxt = S_WAIT;
          w_kill_nxt  = redirect_valid;
        end
      end
      S_WAIT: begin
        if (imem_resp_valid) begin
          if (r_kill || redirect_valid) begin
            w_kill_nxt  = 1'b0;
            w_state_nxt = S_REQ;
          end else begin
            w_pkt_nxt   = '{inst: imem_resp_data, pc: r_pc};
            w_vld_nxt   = 1'b1;
            w_pc_nxt    = r_pc + 32'd4;
            w_state_nxt = S_HOLD;
          end
        end else if (redirect_valid) begin
          w_kill_nxt = 1'b1;
        end
      end
      S_HOLD: begin
        // if_pc is left alone on clear; only the instruction reverts to NOP.
        if (redirect_valid || if_ready) begin
          w_vld_nxt      = 1'b0;
          w_pkt_nxt.inst = NOP_INST;
          w_state_nxt    = S_REQ;
        end
      end
      default: w_state_nxt = S_REQ;
    endcase
  end

  // Gated by reset_n so no request is visible while reset is held.
  assign imem_req_valid = reset_n & (r_state == S_REQ);
  assign imem_addr      = r_pc;
  assign if_valid       = r_vld;
  assign if_inst        = r_pkt.inst;
  assign if_pc          = r_pkt.pc;
  assign misalign_pulse = r_misalign;

endmodule

// File: tb/tb_instruction_fetch.sv
// Scoreboard bench for instruction_fetch: expected {pc,inst} pushed when a
// response is delivered that should survive, popped when if_valid shows up.
module tb_instruction_fetch;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        imem_req_valid, imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        if_valid, if_ready;
  logic [31:0] if_inst, if_pc;
  logic        misalign_pulse;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
  } exp_t;
  exp_t sb_q[$];

  int n_chk = 0;
  int n_pass = 0;

  instruction_fetch #(.RESET_PC(32'h0), .NOP_INST(NOP)) dut (
    .clk(clk), .reset_n(reset_n),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_addr(imem_addr), .imem_resp_valid(imem_resp_valid),
    .imem_resp_data(imem_resp_data), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .if_valid(if_valid), .if_ready(if_ready),
    .if_inst(if_inst), .if_pc(if_pc), .misalign_pulse(misalign_pulse)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", tag, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic wait_req();
    for (int i = 0; i < 20 && !imem_req_valid; i++) tick();
    chk("req_valid", {31'b0, imem_req_valid}, 32'd1);
  endtask

  task automatic req_accept(input logic [31:0] exp_addr);
    wait_req();
    chk("req_addr", imem_addr, exp_addr);
    imem_req_ready = 1'b1;
    tick();
    imem_req_ready = 1'b0;
  endtask

  task automatic respond(input logic [31:0] data, input logic [31:0] pc, input bit keep);
    imem_resp_valid = 1'b1;
    imem_resp_data  = data;
    if (keep) sb_q.push_back('{pc: pc, inst: data});
    tick();
    imem_resp_valid = 1'b0;
    imem_resp_data  = 32'hDEAD_BEEF;
  endtask

  task automatic pop_cmp();
    exp_t e;
    for (int i = 0; i < 20 && !if_valid; i++) tick();
    chk("if_valid", {31'b0, if_valid}, 32'd1);
    chk("sb_pending", {31'b0, sb_q.size() != 0}, 32'd1);
    if (sb_q.size() != 0) begin
      e = sb_q.pop_front();
      chk("if_inst", if_inst, e.inst);
      chk("if_pc", if_pc, e.pc);
    end
  endtask

  task automatic consume();
    pop_cmp();
    if_ready = 1'b1;
    tick();
    if_ready = 1'b0;
    chk("valid_clr", {31'b0, if_valid}, 32'd0);
    chk("nop_clr", if_inst, NOP);
  endtask

  task automatic redirect(input logic [31:0] pc);
    redirect_valid = 1'b1;
    redirect_pc    = pc;
  endtask

  initial begin
    reset_n = 1'b0; imem_req_ready = 1'b0; imem_resp_valid = 1'b0;
    imem_resp_data = 32'h0; redirect_valid = 1'b0; redirect_pc = 32'h0; if_ready = 1'b0;
    tick(); tick();
    chk("rst_req_valid", {31'b0, imem_req_valid}, 32'd0);
    chk("rst_if_valid", {31'b0, if_valid}, 32'd0);
    chk("rst_if_inst", if_inst, NOP);
    chk("rst_if_pc", if_pc, 32'h0);
    chk("rst_misalign", {31'b0, misalign_pulse}, 32'd0);
    reset_n = 1'b1;
    #1;
    chk("post_rst_req", {31'b0, imem_req_valid}, 32'd1);
    chk("post_rst_addr", imem_addr, 32'h0);

    // first fetch: if_valid one cycle after the response
    req_accept(32'h0);
    respond(32'h0050_0093, 32'h0, 1);
    chk("latency", {31'b0, if_valid}, 32'd1);
    consume();

    // decode stalls for 5 cycles in HOLD
    req_accept(32'h4);
    respond(32'h1234_5678, 32'h4, 1);
    for (int i = 0; i < 5; i++) begin
      chk("stall_inst", if_inst, 32'h1234_5678);
      chk("stall_pc", if_pc, 32'h4);
      chk("stall_noreq", {31'b0, imem_req_valid}, 32'd0);
      tick();
    end
    consume();

    // memory back-pressure and slow response
    for (int i = 0; i < 3; i++) begin
      chk("bp_addr", imem_addr, 32'h8);
      tick();
    end
    req_accept(32'h8);
    for (int i = 0; i < 2; i++) begin
      chk("wait_noreq", {31'b0, imem_req_valid}, 32'd0);
      tick();
    end
    respond(32'hA0A0_0008, 32'h8, 1);
    consume();

    // redirect in WAIT, response the cycle after is dropped
    req_accept(32'hC);
    redirect(32'h100);
    tick();
    redirect_valid = 1'b0;
    respond(32'hBAD0_000C, 32'hC, 0);
    chk("kill_valid0", {31'b0, if_valid}, 32'd0);
    tick();
    chk("kill_valid1", {31'b0, if_valid}, 32'd0);
    req_accept(32'h100);
    respond(32'h0000_0100, 32'h100, 1);
    consume();

    // redirect coincident with request accept
    wait_req();
    chk("race_addr", imem_addr, 32'h104);
    imem_req_ready = 1'b1;
    redirect(32'h200);
    tick();
    imem_req_ready = 1'b0; redirect_valid = 1'b0;
    respond(32'hBAD0_0104, 32'h104, 0);
    chk("race_valid", {31'b0, if_valid}, 32'd0);
    req_accept(32'h200);
    respond(32'h0000_0200, 32'h200, 1);
    consume();

    // misaligned redirect
    redirect(32'h203);
    tick();
    redirect_valid = 1'b0;
    chk("misalign_hi", {31'b0, misalign_pulse}, 32'd1);
    chk("misalign_addr", imem_addr, 32'h200);
    tick();
    chk("misalign_lo", {31'b0, misalign_pulse}, 32'd0);
    req_accept(32'h200);
    respond(32'h0000_0201, 32'h200, 1);
    consume();

    // redirect and response in the same WAIT cycle
    req_accept(32'h204);
    imem_resp_valid = 1'b1; imem_resp_data = 32'hBAD0_0204;
    redirect(32'h300);
    tick();
    imem_resp_valid = 1'b0; redirect_valid = 1'b0;
    chk("samecyc_valid", {31'b0, if_valid}, 32'd0);
    chk("samecyc_addr", imem_addr, 32'h300);

    // redirect while HOLDing flushes the instruction but keeps if_pc
    req_accept(32'h300);
    respond(32'h0000_0300, 32'h300, 1);
    pop_cmp();
    redirect(32'h400);
    tick();
    redirect_valid = 1'b0;
    chk("hold_redir_valid", {31'b0, if_valid}, 32'd0);
    chk("hold_redir_inst", if_inst, NOP);
    chk("hold_redir_pc", if_pc, 32'h300);
    chk("hold_redir_addr", imem_addr, 32'h400);

    // stray response outside WAIT is ignored
    imem_resp_valid = 1'b1; imem_resp_data = 32'hBAD0_0400;
    tick();
    imem_resp_valid = 1'b0;
    chk("stray_valid", {31'b0, if_valid}, 32'd0);
    chk("stray_req", {31'b0, imem_req_valid}, 32'd1);

    // address wrap at top of memory
    redirect(32'hFFFF_FFFC);
    tick();
    redirect_valid = 1'b0;
    req_accept(32'hFFFF_FFFC);
    respond(32'h0000_FFFC, 32'hFFFF_FFFC, 1);
    consume();
    req_accept(32'h0);

    // reset in WAIT, late response afterwards is ignored
    reset_n = 1'b0;
    #1;
    chk("midrst_req", {31'b0, imem_req_valid}, 32'd0);
    chk("midrst_valid", {31'b0, if_valid}, 32'd0);
    chk("midrst_inst", if_inst, NOP);
    tick();
    reset_n = 1'b1;
    imem_resp_valid = 1'b1; imem_resp_data = 32'hBAD0_0000;
    #1;
    chk("rerst_req", {31'b0, imem_req_valid}, 32'd1);
    chk("rerst_addr", imem_addr, 32'h0);
    tick();
    imem_resp_valid = 1'b0;
    chk("late_resp_valid", {31'b0, if_valid}, 32'd0);
    chk("late_resp_req", {31'b0, imem_req_valid}, 32'd1);
    chk("sb_empty", sb_q.size(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: %0d/%0d checks passed", n_pass, n_chk);
    $fatal(1);
  end
endmodule

// File: doc/instruction_fetch.md
INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000: PC fetched first after reset; bits [1:0] SHALL be 0.
REQ-002 Parameter NOP_INST, default 32'h0000_0013: value on if_inst when no valid instruction is held.
REQ-003 clk  in  1  sole clock; all state SHALL update on its rising edge.
REQ-004 reset_n  in  1  reset, asynchronous assert, active-low.
REQ-005 imem_req_valid  out  1  fetch request to instruction memory.
REQ-006 imem_req_ready  in  1  memory accepts the request this cycle.
REQ-007 imem_addr  out  32  byte address of the request (word-aligned).
REQ-008 imem_resp_valid  in  1  response data valid this cycle.
REQ-009 imem_resp_data  in  32  fetched instruction word.
REQ-010 redirect_valid  in  1  branch/jump target from execute; one-cycle pulse.
REQ-011 redirect_pc  in  32  new fetch PC.
REQ-012 if_valid  out  1  if_inst/if_pc hold an instruction for decode and immediate generation.
REQ-013 if_ready  in  1  decode consumes the instruction this cycle.
REQ-014 if_inst  out  32  registered instruction word.
REQ-015 if_pc  out  32  PC of if_inst.
REQ-016 misalign_pulse  out  1  one-cycle flag: redirect_pc[1:0] was nonzero.

Function
REQ-017 States SHALL be REQ, WAIT, HOLD; at most one memory request SHALL be outstanding.
REQ-018 REQ: imem_req_valid=1, imem_addr=pc; on imem_req_ready -> WAIT; otherwise stay in REQ with imem_addr stable.
REQ-019 WAIT: imem_req_valid=0; on imem_resp_valid with kill=0: if_inst<=imem_resp_data, if_pc<=pc, if_valid<=1, pc<=pc+4 (mod 2^32, wrap from 32'hFFFF_FFFC to 0) -> HOLD.
REQ-020 WAIT with kill=1: response SHALL be discarded, kill<=0 -> REQ; no if_valid assertion.
REQ-021 HOLD: if_valid=1, outputs stable; on if_ready -> if_valid<=0, if_inst<=NOP_INST -> REQ.
REQ-022 Latency: request accepted at cycle N, response at cycle M>N, if_valid high at cycle M+1; back-to-back with instant ready/response: one instruction per 3 cycles.
REQ-023 Redirect SHALL load pc<={redirect_pc[31:2],2'b00}; misalign_pulse<=|redirect_pc[1:0] next cycle.
REQ-024 Redirect in REQ without imem_req_ready: stay in REQ, next request uses new pc.
REQ-025 Redirect in REQ with imem_req_ready same cycle: old request accepted, -> WAIT with kill<=1.
REQ-026 Redirect in WAIT (with or without imem_resp_valid same cycle): kill<=1 unless response arrives same cycle, in which case response discarded and -> REQ directly.
REQ-027 Redirect in HOLD: if_valid<=0, if_inst<=NOP_INST -> REQ; if if_ready same cycle, handshake counts as completed (decode keeps the instruction), pc still takes redirect.
REQ-028 Redirect SHALL never alter a held if_inst/if_pc except clearing per REQ-027.
REQ-029 imem_resp_valid outside WAIT SHALL be ignored.
REQ-030 if_inst SHALL equal NOP_INST whenever if_valid=0.

Reset
REQ-031 reset_n low SHALL asynchronously set: state=REQ, pc=RESET_PC, kill=0, if_valid=0, if_inst=NOP_INST, if_pc=0, misalign_pulse=0.
REQ-032 imem_req_valid SHALL be 0 while reset_n low and SHALL be 1 in the first cycle after deassertion, imem_addr=RESET_PC.
REQ-033 Reset mid-operation (any state, including outstanding request) SHALL abandon all state; a later response SHALL be ignored per REQ-029.

Verification
REQ-034 Reset release, ready=1, response 1 cycle later with 32'h00500093 -> if_valid with if_inst=32'h00500093, if_pc=0; next request addr=4.
REQ-035 if_ready held 0 for 5 cycles in HOLD -> if_inst/if_pc stable, imem_req_valid=0 throughout; release -> request addr=pc+4.
REQ-036 redirect_valid with redirect_pc=32'h100 in WAIT, response next cycle -> response dropped, if_valid stays 0, next request addr=32'h100.
REQ-037 redirect same cycle as imem_req_ready in REQ (redirect_pc=32'h200) -> old response discarded, following request addr=32'h200.
REQ-038 redirect_pc=32'h203 -> misalign_pulse one cycle, next imem_addr=32'h200.
REQ-039 pc=32'hFFFF_FFFC fetch completes -> next request addr=32'h0; reset_n pulsed low in WAIT -> imem_req_valid 0 immediately, if_valid 0, if_inst=NOP_INST.
